// File: rtl/req_encoder16_pkg.sv
`default_nettype none
// ============================================================================
// Module      : req_encoder16_pkg
// Description : Shared constants and state type for the 16-to-4 request
//               encoder and its priority-encoder sub-block.
// Revision    : 1.0 - initial release
// ============================================================================
package req_encoder16_pkg;

  localparam int N         = 16;
  localparam int IDX_W     = 4;
  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Output-stage state; PRESENT is exactly the out_valid condition.
  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } state_e;

endpackage : req_encoder16_pkg
`default_nettype wire

// File: rtl/req_encoder16_prio_enc16.sv
`default_nettype none
// ============================================================================
// Module      : prio_enc16
// Description : Combinational rotating priority encoder. Rotates vec right
//               by start, finds the lowest set bit, then adds start back
//               (mod 16) so the result is an absolute index.
// Revision    : 1.0 - initial release
// ============================================================================
module prio_enc16
  import req_encoder16_pkg::*;
(
  input  logic [N-1:0]     vec,
  input  logic [IDX_W-1:0] start,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  logic [N-1:0]     rot;
  logic [IDX_W-1:0] low;

  // Rotate so the search begins at 'start', then pick the lowest set bit.
  always_comb begin
    rot = (vec >> start) | (vec << (N - int'(start)));
    low = '0;
    // Descending scan so the lowest set position is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        low = i[IDX_W-1:0];
      end
    end
    idx   = low + start;
    found = |vec;
  end

endmodule : prio_enc16
`default_nettype wire

// File: rtl/req_encoder16.sv
`default_nettype none
// ============================================================================
// Module      : req_encoder16
// Description : Sequential 16-to-4 encoder. Captures request pulses into a
//               pending register and emits one index per pending request over
//               a valid/ready handshake, fixed-priority or round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module req_encoder16
  import req_encoder16_pkg::*;
#(
  parameter int ARB_MODE = ARB_FIXED
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             clr,
  input  logic [N-1:0]     req,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     pending,
  output logic             overflow
);

  state_e           state_q, state_d;
  logic [N-1:0]     pend_q, pend_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic             ovf_q, ovf_d;

  logic [N-1:0]     gated_req;
  logic [N-1:0]     load_mask;
  logic [IDX_W-1:0] search_start;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_found;
  logic             load;

  // Fixed mode always searches from 0; round-robin starts just past the
  // last index served.
  assign search_start = (ARB_MODE == ARB_RR) ? last_q + 4'd1 : '0;

  prio_enc16 u_prio (
    .vec   (pend_q),
    .start (search_start),
    .idx   (sel_idx),
    .found (sel_found)
  );

  // Next-state logic: capture, selection/load, handshake and flush.
  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    idx_d     = idx_q;
    last_d    = last_q;
    ovf_d     = ovf_q;
    gated_req = enable ? req : '0;
    // Selection uses registered pending only, never same-cycle req.
    load      = sel_found && ((state_q == ST_IDLE) || out_ready);
    load_mask = load ? (N'(1) << sel_idx) : '0;

    if (clr) begin
      state_d = ST_IDLE;
      pend_d  = '0;
      idx_d   = '0;
      last_d  = 4'd15;
      ovf_d   = 1'b0;
    end else begin
      // A bit being loaded this edge may be re-set by a fresh request
      // without counting as overflow.
      pend_d = (pend_q & ~load_mask) | gated_req;
      if (|(gated_req & pend_q & ~load_mask)) begin
        ovf_d = 1'b1;
      end
      if (load) begin
        state_d = ST_PRESENT;
        idx_d   = sel_idx;
        last_d  = sel_idx;
      end else if ((state_q == ST_PRESENT) && out_ready) begin
        state_d = ST_IDLE;
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      idx_q   <= '0;
      last_q  <= 4'd15;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_valid = (state_q == ST_PRESENT);
  assign out_idx   = idx_q;
  assign pending   = pend_q;
  assign overflow  = ovf_q;

endmodule : req_encoder16
`default_nettype wire

// File: tb/tb_req_encoder16.sv
`default_nettype none
// ============================================================================
// Module      : tb_req_encoder16
// Description : Directed bench for req_encoder16; one fixed-priority and one
//               round-robin instance share the same stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_req_encoder16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        clr;
  logic [15:0] req;
  logic        out_ready;

  logic [3:0]  f_idx, r_idx;
  logic        f_valid, r_valid;
  logic [15:0] f_pend, r_pend;
  logic        f_ovf, r_ovf;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  req_encoder16 #(.ARB_MODE(0)) u_fix (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clr(clr), .req(req),
    .out_idx(f_idx), .out_valid(f_valid), .out_ready(out_ready),
    .pending(f_pend), .overflow(f_ovf)
  );

  req_encoder16 #(.ARB_MODE(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clr(clr), .req(req),
    .out_idx(r_idx), .out_valid(r_valid), .out_ready(out_ready),
    .pending(r_pend), .overflow(r_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks one instance's output stage (valid and, when valid, index).
  task automatic chk_out(input string tag, input logic v, input logic [3:0] i,
                         input logic ev, input logic [3:0] ei);
    chk({tag, "_valid"}, {31'd0, v}, {31'd0, ev});
    if (ev) chk({tag, "_idx"}, {28'd0, i}, {28'd0, ei});
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1; clr = 1'b0; req = '0; out_ready = 1'b1;
    step(); step();
    chk("rst_pend",  {16'd0, f_pend}, 32'h0);
    chk("rst_valid", {31'd0, f_valid}, 32'h0);
    chk("rst_idx",   {28'd0, f_idx}, 32'h0);
    chk("rst_ovf",   {31'd0, r_ovf}, 32'h0);
    rst_n = 1'b1;
    step();

    // Single pulse: visible in pending after one edge, presented after two.
    req = 16'h0020; step(); req = '0;
    chk("t1_pend", {16'd0, f_pend}, 32'h0020);
    chk("t1_early_valid", {31'd0, f_valid}, 32'h0);
    step();
    chk_out("t1_fix", f_valid, f_idx, 1'b1, 4'd5);
    chk_out("t1_rr",  r_valid, r_idx, 1'b1, 4'd5);
    chk("t1_pend0", {16'd0, f_pend}, 32'h0);
    step();
    chk("t1_drop", {31'd0, f_valid}, 32'h0);
    chk("t1_ovf",  {31'd0, f_ovf}, 32'h0);

    // 0x8421 burst: fixed 0,5,10,15; round-robin after last=5 gives 10,15,0,5.
    req = 16'h8421; step(); req = '0;
    chk("t2_pend", {16'd0, f_pend}, 32'h8421);
    step(); chk_out("t2_f0", f_valid, f_idx, 1'b1, 4'd0);  chk_out("t2_r0", r_valid, r_idx, 1'b1, 4'd10);
    step(); chk_out("t2_f1", f_valid, f_idx, 1'b1, 4'd5);  chk_out("t2_r1", r_valid, r_idx, 1'b1, 4'd15);
    step(); chk_out("t2_f2", f_valid, f_idx, 1'b1, 4'd10); chk_out("t2_r2", r_valid, r_idx, 1'b1, 4'd0);
    step(); chk_out("t2_f3", f_valid, f_idx, 1'b1, 4'd15); chk_out("t2_r3", r_valid, r_idx, 1'b1, 4'd5);
    step(); chk("t2_end", {31'd0, f_valid}, 32'h0);

    // Round-robin fairness: 0 served, new req 0 arrives, 15 must win next.
    clr = 1'b1; step(); clr = 1'b0;
    req = 16'h8001; step(); req = '0;
    step();
    chk_out("t3_f0", f_valid, f_idx, 1'b1, 4'd0); chk_out("t3_r0", r_valid, r_idx, 1'b1, 4'd0);
    out_ready = 1'b0; req = 16'h0001; step(); req = '0;
    chk("t3_pend", {16'd0, r_pend}, 32'h8001);
    chk_out("t3_hold", r_valid, r_idx, 1'b1, 4'd0);
    out_ready = 1'b1; step();
    chk_out("t3_f1", f_valid, f_idx, 1'b1, 4'd0); chk_out("t3_r1", r_valid, r_idx, 1'b1, 4'd15);
    step();
    chk_out("t3_f2", f_valid, f_idx, 1'b1, 4'd15); chk_out("t3_r2", r_valid, r_idx, 1'b1, 4'd0);
    step(); chk("t3_end", {31'd0, r_valid}, 32'h0);

    // Backpressure: index 1 held for 5 stalled cycles, then 2.
    out_ready = 1'b0; req = 16'h0006; step(); req = '0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk_out("t4_hold_f", f_valid, f_idx, 1'b1, 4'd1);
      chk_out("t4_hold_r", r_valid, r_idx, 1'b1, 4'd1);
    end
    chk("t4_pend", {16'd0, f_pend}, 32'h0004);
    out_ready = 1'b1; step();
    chk_out("t4_f2", f_valid, f_idx, 1'b1, 4'd2); chk_out("t4_r2", r_valid, r_idx, 1'b1, 4'd2);
    step(); chk("t4_end", {31'd0, f_valid}, 32'h0);

    // Overflow: bit 3 requested twice while the output stage is busy.
    req = 16'h0001; step();
    out_ready = 1'b0; req = 16'h0008; step();
    chk_out("t5_busy", f_valid, f_idx, 1'b1, 4'd0);
    chk("t5_noovf", {31'd0, f_ovf}, 32'h0);
    step(); req = '0;
    chk("t5_ovf", {31'd0, f_ovf}, 32'h1);
    chk("t5_ovf_rr", {31'd0, r_ovf}, 32'h1);
    step();
    chk("t5_sticky", {31'd0, f_ovf}, 32'h1);
    chk("t5_pend", {16'd0, f_pend}, 32'h0008);
    out_ready = 1'b1; step();
    chk_out("t5_f3", f_valid, f_idx, 1'b1, 4'd3); chk_out("t5_r3", r_valid, r_idx, 1'b1, 4'd3);
    step();
    chk("t5_once", {31'd0, f_valid}, 32'h0);
    chk("t5_sticky2", {31'd0, f_ovf}, 32'h1);
    clr = 1'b1; step(); clr = 1'b0;
    chk("t5_clr_ovf", {31'd0, f_ovf}, 32'h0);
    chk("t5_clr_pend", {16'd0, f_pend}, 32'h0);

    // Same-cycle re-request of the bit being loaded: new event, no overflow.
    req = 16'h0010; step(); step(); req = '0;
    chk_out("t6_a", f_valid, f_idx, 1'b1, 4'd4);
    chk("t6_pend", {16'd0, f_pend}, 32'h0010);
    chk("t6_noovf", {31'd0, f_ovf}, 32'h0);
    step();
    chk_out("t6_b_f", f_valid, f_idx, 1'b1, 4'd4); chk_out("t6_b_r", r_valid, r_idx, 1'b1, 4'd4);
    step(); chk("t6_end", {31'd0, f_valid}, 32'h0);

    // clr while presenting with pending=FF00; req in the clr cycle is dropped.
    out_ready = 1'b0; req = 16'hFF01; step(); req = '0; step();
    chk_out("t7_f", f_valid, f_idx, 1'b1, 4'd0);
    chk_out("t7_r", r_valid, r_idx, 1'b1, 4'd8);
    chk("t7_pend", {16'd0, f_pend}, 32'hFF00);
    clr = 1'b1; req = 16'h00F0; step(); clr = 1'b0; req = '0;
    chk("t7_valid", {31'd0, f_valid}, 32'h0);
    chk("t7_pend0", {16'd0, f_pend}, 32'h0);
    chk("t7_pend0_rr", {16'd0, r_pend}, 32'h0);

    // enable=0 blocks capture entirely.
    enable = 1'b0; req = 16'hFFFF; step(); step(); req = '0; enable = 1'b1;
    chk("t8_pend", {16'd0, f_pend}, 32'h0);
    chk("t8_valid", {31'd0, f_valid}, 32'h0);

    // Asynchronous reset mid-transfer.
    req = 16'hFF01; step(); req = '0; step();
    chk("t9_pre", {31'd0, f_valid}, 32'h1);
    #2 rst_n = 1'b0; #1;
    chk("t9_valid", {31'd0, f_valid}, 32'h0);
    chk("t9_pend",  {16'd0, f_pend}, 32'h0);
    chk("t9_rr_valid", {31'd0, r_valid}, 32'h0);
    step(); rst_n = 1'b1; out_ready = 1'b1; step();
    chk("t9_after", {16'd0, f_pend}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_req_encoder16
`default_nettype wire
